activation_write_sequencer: RTL and testbench

- Producer side of the activation memory unit's write port. Accepts a valid/ready stream of activation words and converts it into per-BRAM write-enable pulses, a shared write address and write data.
- Drives the memory unit's en_bus, w_addr and data_in directly.
- Two placement modes:
  - Interleaved: word k goes to BRAM k mod BRAM_COUNT.
  - Broadcast: every word goes to all BRAMs.
- Sits between the DMA/input-feature loader and the activation memory unit.

---
 rtl/activation_write_sequencer_pkg.sv | 18 +
 rtl/activation_write_sequencer_if.sv | 11 +
 rtl/activation_write_sequencer_bank_row_counter.sv | 52 +++++
 rtl/activation_write_sequencer.sv | 132 +++++++++++++
 tb/tb_activation_write_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/activation_write_sequencer_pkg.sv
// Shared encodings for the activation write sequencer and its bank/row counter.
package activation_write_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_INTERLEAVE = 1'b0;
    localparam logic MODE_BROADCAST  = 1'b1;

    // A single bank still needs a one-bit index.
    function automatic int bank_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/activation_write_sequencer_if.sv
// Valid/ready activation word stream from the loader into the write sequencer.
interface activation_write_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/activation_write_sequencer_bank_row_counter.sv
// Mod-BRAM_COUNT bank counter carrying into a row counter; broadcast steps the row directly.
module bank_row_counter
    import activation_write_sequencer_pkg::*;
#(
    parameter int BRAM_COUNT = 5,
    parameter int ADDR_WIDTH = 4,
    localparam int BANK_W    = bank_width(BRAM_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  step,
    input  logic                  broadcast,
    output logic [BANK_W-1:0]     bank,
    output logic [ADDR_WIDTH-1:0] row
);

    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;

    always_comb begin
        bank_d = bank_q;
        row_d  = row_q;
        if (clear) begin
            bank_d = '0;
            row_d  = '0;
        end else if (step) begin
            if (broadcast) begin
                row_d = row_q + ADDR_WIDTH'(1);
            end else if (bank_q == BANK_W'(BRAM_COUNT - 1)) begin
                bank_d = '0;
                row_d  = row_q + ADDR_WIDTH'(1);
            end else begin
                bank_d = bank_q + BANK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
            row_q  <= '0;
        end else begin
            bank_q <= bank_d;
            row_q  <= row_d;
        end
    end

    assign bank = bank_q;
    assign row  = row_q;

endmodule

// File: rtl/activation_write_sequencer.sv
// Turns an activation word stream into per-BRAM write pulses with a shared address and data bus.
module activation_write_sequencer
    import activation_write_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BRAM_COUNT = 5,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    activation_write_sequencer_if.slave stream,
    output logic [BRAM_COUNT-1:0] en_bus,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done
);

    localparam int BANK_W = bank_width(BRAM_COUNT);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [BRAM_COUNT-1:0] en_q, en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  clear;
    logic                  ready;
    logic                  hs;
    logic [BANK_W-1:0]     bank;
    logic [ADDR_WIDTH-1:0] row;
    logic [BRAM_COUNT-1:0] onehot;

    // Gating with rst keeps a word from being taken on the very edge that aborts the transfer.
    assign ready        = (state_q == WRITE) && (cnt_q < len_q) && !rst;
    assign hs           = stream.s_valid && ready;
    assign stream.s_ready = ready;

    bank_row_counter #(
        .BRAM_COUNT (BRAM_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank_row (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .step      (hs),
        .broadcast (mode_q == MODE_BROADCAST),
        .bank      (bank),
        .row       (row)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    base_d  = base_addr;
                    len_d   = length;
                    cnt_d   = '0;
                    clear   = 1'b1;
                    state_d = (length == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (hs) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (cnt_q + LEN_WIDTH'(1) == len_q) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        onehot = '0;
        for (int i = 0; i < BRAM_COUNT; i++) onehot[i] = (bank == BANK_W'(i));
    end

    always_comb begin
        en_d   = '0;
        addr_d = addr_q;
        data_d = data_q;
        if (hs) begin
            en_d   = (mode_q == MODE_BROADCAST) ? '1 : onehot;
            addr_d = base_q + row;
            data_d = stream.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_INTERLEAVE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign en_bus  = en_q;
    assign w_addr  = addr_q;
    assign data_in = data_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_activation_write_sequencer.sv
// Directed bench for activation_write_sequencer with hand-computed write sequences.
module tb_activation_write_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [3:0] base_addr;
    logic [7:0] length;
    logic [4:0] en_bus;
    logic [3:0] w_addr;
    logic [7:0] data_in;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    activation_write_sequencer_if #(.DATA_WIDTH(8)) s_if ();

    activation_write_sequencer #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8),
        .BRAM_COUNT (5),
        .LEN_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .length    (length),
        .stream    (s_if.slave),
        .en_bus    (en_bus),
        .w_addr    (w_addr),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_xfer(input logic m, input logic [3:0] b, input logic [7:0] l);
        start = 1'b1; mode = m; base_addr = b; length = l;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0;
        s_if.s_valid = 1'b0; s_if.s_data = '0;
        step(); step();
        checks++; if (en_bus !== 5'd0) begin errors++; $display("FAIL reset_en got=%b exp=00000", en_bus); end
        checks++; if (w_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", w_addr); end
        checks++; if (data_in !== 8'd0) begin errors++; $display("FAIL reset_data got=%h exp=00", data_in); end
        checks++; if ({s_if.s_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got ready/busy/done=%b exp=000", {s_if.s_ready, busy, done}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_interleave();
        logic [4:0] exp_en [7]   = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02};
        logic [3:0] exp_addr [7] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3};
        begin_xfer(1'b0, 4'd2, 8'd7);
        s_if.s_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            s_if.s_data = 8'h10 + 8'(k);
            checks++; if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL il_ready[%0d] got=%b exp=1", k, s_if.s_ready); end
            step();
            checks++; if (en_bus !== exp_en[k]) begin errors++; $display("FAIL il_en[%0d] got=%b exp=%b", k, en_bus, exp_en[k]); end
            checks++; if (w_addr !== exp_addr[k]) begin errors++; $display("FAIL il_addr[%0d] got=%0d exp=%0d", k, w_addr, exp_addr[k]); end
            checks++; if (data_in !== 8'h10 + 8'(k)) begin errors++; $display("FAIL il_data[%0d] got=%h exp=%h", k, data_in, 8'h10 + 8'(k)); end
            checks++; if ({busy, done} !== {1'b1, k == 6}) begin errors++; $display("FAIL il_busy_done[%0d] got=%b exp=%b", k, {busy, done}, {1'b1, k == 6}); end
        end
        checks++; if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL il_ready_done got=%b exp=0", s_if.s_ready); end
        step();
        s_if.s_valid = 1'b0;
        checks++; if ({busy, done, en_bus} !== 7'd0) begin errors++; $display("FAIL il_idle got busy/done/en=%b exp=0000000", {busy, done, en_bus}); end
    endtask

    task automatic test_broadcast_wrap();
        logic [3:0] exp_addr [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        begin_xfer(1'b1, 4'd14, 8'd4);
        s_if.s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_if.s_data = 8'hA0 + 8'(k);
            step();
            checks++; if (en_bus !== 5'h1F) begin errors++; $display("FAIL bc_en[%0d] got=%b exp=11111", k, en_bus); end
            checks++; if (w_addr !== exp_addr[k]) begin errors++; $display("FAIL bc_addr[%0d] got=%0d exp=%0d", k, w_addr, exp_addr[k]); end
            checks++; if (data_in !== 8'hA0 + 8'(k)) begin errors++; $display("FAIL bc_data[%0d] got=%h exp=%h", k, data_in, 8'hA0 + 8'(k)); end
            checks++; if (done !== (k == 3)) begin errors++; $display("FAIL bc_done[%0d] got=%b exp=%b", k, done, k == 3); end
        end
        s_if.s_valid = 1'b0;
        step();
        checks++; if ({busy, en_bus} !== 6'd0) begin errors++; $display("FAIL bc_idle got busy/en=%b exp=000000", {busy, en_bus}); end
    endtask

    task automatic test_gaps();
        logic       vld [5]      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [4:0] exp_en [5]   = '{5'h01, 5'h00, 5'h00, 5'h02, 5'h04};
        logic [7:0] exp_data [5] = '{8'h30, 8'h30, 8'h30, 8'h33, 8'h34};
        logic       exp_rdy [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        begin_xfer(1'b0, 4'd5, 8'd3);
        for (int i = 0; i < 5; i++) begin
            s_if.s_valid = vld[i];
            s_if.s_data  = 8'h30 + 8'(i);
            step();
            checks++; if (en_bus !== exp_en[i]) begin errors++; $display("FAIL gap_en[%0d] got=%b exp=%b", i, en_bus, exp_en[i]); end
            checks++; if (data_in !== exp_data[i]) begin errors++; $display("FAIL gap_data[%0d] got=%h exp=%h", i, data_in, exp_data[i]); end
            checks++; if (w_addr !== 4'd5) begin errors++; $display("FAIL gap_addr[%0d] got=%0d exp=5", i, w_addr); end
            checks++; if (s_if.s_ready !== exp_rdy[i]) begin errors++; $display("FAIL gap_ready[%0d] got=%b exp=%b", i, s_if.s_ready, exp_rdy[i]); end
            checks++; if (done !== (i == 4)) begin errors++; $display("FAIL gap_done[%0d] got=%b exp=%b", i, done, i == 4); end
        end
        s_if.s_valid = 1'b0;
        step();
    endtask

    task automatic test_zero_length();
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'hEE;
        begin_xfer(1'b0, 4'd9, 8'd0);
        checks++; if ({done, busy, s_if.s_ready, en_bus} !== 8'b1100_0000) begin errors++; $display("FAIL zl_first got done/busy/ready/en=%b exp=11000000", {done, busy, s_if.s_ready, en_bus}); end
        step();
        checks++; if ({done, busy, s_if.s_ready, en_bus} !== 8'd0) begin errors++; $display("FAIL zl_second got done/busy/ready/en=%b exp=00000000", {done, busy, s_if.s_ready, en_bus}); end
        checks++; if (data_in === 8'hEE) begin errors++; $display("FAIL zl_data got=%h exp=not EE", data_in); end
        s_if.s_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic [4:0] exp_en [3] = '{5'h01, 5'h02, 5'h04};
        begin_xfer(1'b0, 4'd1, 8'd3);
        s_if.s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_if.s_data = 8'h60 + 8'(k);
            if (k == 1) begin
                start = 1'b1; mode = 1'b1; base_addr = 4'd9; length = 8'd6;
            end
            step();
            start = 1'b0;
            checks++; if (en_bus !== exp_en[k]) begin errors++; $display("FAIL si_en[%0d] got=%b exp=%b", k, en_bus, exp_en[k]); end
            checks++; if (w_addr !== 4'd1) begin errors++; $display("FAIL si_addr[%0d] got=%0d exp=1", k, w_addr); end
            checks++; if (done !== (k == 2)) begin errors++; $display("FAIL si_done[%0d] got=%b exp=%b", k, done, k == 2); end
        end
        step();
        checks++; if ({busy, s_if.s_ready, en_bus} !== 7'd0) begin errors++; $display("FAIL si_idle got busy/ready/en=%b exp=0000000", {busy, s_if.s_ready, en_bus}); end
        s_if.s_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        begin_xfer(1'b0, 4'd4, 8'd6);
        s_if.s_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_if.s_data = 8'h40 + 8'(k);
            step();
            checks++; if (en_bus !== (5'h01 << k)) begin errors++; $display("FAIL rm_en[%0d] got=%b exp=%b", k, en_bus, 5'h01 << k); end
        end
        rst = 1'b1;
        #1;
        checks++; if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_rst got=%b exp=0", s_if.s_ready); end
        step();
        checks++; if ({en_bus, busy, done} !== 7'd0) begin errors++; $display("FAIL rm_after_rst got en/busy/done=%b exp=0000000", {en_bus, busy, done}); end
        rst = 1'b0;
        s_if.s_valid = 1'b0;
        step();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rm_no_done got busy/done=%b exp=00", {busy, done}); end
        begin_xfer(1'b0, 4'd0, 8'd2);
        s_if.s_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_if.s_data = 8'h51 + 8'(k);
            step();
            checks++; if (en_bus !== (5'h01 << k)) begin errors++; $display("FAIL rm_new_en[%0d] got=%b exp=%b", k, en_bus, 5'h01 << k); end
            checks++; if (w_addr !== 4'd0) begin errors++; $display("FAIL rm_new_addr[%0d] got=%0d exp=0", k, w_addr); end
            checks++; if (data_in !== 8'h51 + 8'(k)) begin errors++; $display("FAIL rm_new_data[%0d] got=%h exp=%h", k, data_in, 8'h51 + 8'(k)); end
            checks++; if (done !== (k == 1)) begin errors++; $display("FAIL rm_new_done[%0d] got=%b exp=%b", k, done, k == 1); end
        end
        s_if.s_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_interleave();
        test_broadcast_wrap();
        test_gaps();
        test_zero_length();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
